// File: rtl/note_store_pkg.sv
// note_store_pkg: shared sizing defaults and FSM encoding for the note store.
`timescale 1ns/1ps
package note_store_pkg;

    // Default geometry matches the pad's 12-bit address bus and 4-bit note codes.
    localparam int unsigned NS_ADDR_W = 12;
    localparam int unsigned NS_DATA_W = 4;
    localparam int unsigned DEPTH     = 1 << NS_ADDR_W;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : note_store_pkg

// File: rtl/note_ram.sv
// note_ram: single-port synchronous RAM, one-cycle read, write-priority, no reset.
`timescale 1ns/1ps
module note_ram
    import note_store_pkg::*;
#(
    parameter int unsigned ADDR_W = NS_ADDR_W,
    parameter int unsigned WIDTH  = NS_DATA_W,
    parameter int unsigned DEPTH_P = DEPTH
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH_P];
    logic [WIDTH-1:0] rdata_q;

    // Enabled cycles either write the addressed word or capture it for reading.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : note_ram

// File: rtl/note_store.sv
// note_store: CE-handshaked note memory that tracks the recorded length.
// Optional feature: define NOTE_STORE_PARITY_EN to store an even-parity bit
// per word and add the PErr output.
`timescale 1ns/1ps
module note_store
    import note_store_pkg::*;
#(
    parameter int unsigned ADDR_W = NS_ADDR_W,
    parameter int unsigned DATA_W = NS_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    output logic              Rdy,
    output logic [ADDR_W:0]   Len,
    output logic              Full
`ifdef NOTE_STORE_PARITY_EN
    ,
    output logic              PErr
`endif
);

    localparam int unsigned LEN_W     = ADDR_W + 1;
    localparam int unsigned RAM_DEPTH = (ADDR_W == NS_ADDR_W) ? DEPTH : (1 << ADDR_W);
`ifdef NOTE_STORE_PARITY_EN
    localparam int unsigned RAM_W     = DATA_W + 1;
`else
    localparam int unsigned RAM_W     = DATA_W;
`endif
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1) << ADDR_W;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                rw_q;
    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   dout_d;
    logic                rdy_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic                full_q;
    logic                full_d;
    logic [LEN_W-1:0]    addr_ext_c;
    logic                hit_c;

    logic                ram_en_c;
    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [RAM_W-1:0]    ram_wdata_c;
    logic [RAM_W-1:0]    ram_rdata;

`ifdef NOTE_STORE_PARITY_EN
    logic                perr_q;
    logic                perr_d;
`endif

    // Reads are launched from IDLE on the live address so the word is ready in BUSY;
    // writes are committed from the latched request while in BUSY.
    always_comb begin
        ram_we_c   = (state_q == ST_BUSY) && rw_q;
        ram_en_c   = ((state_q == ST_IDLE) && CE && !RW) || ram_we_c;
        ram_addr_c = (state_q == ST_IDLE) ? Addr : addr_q;
    end

`ifdef NOTE_STORE_PARITY_EN
    assign ram_wdata_c = {^din_q, din_q};
`else
    assign ram_wdata_c = din_q;
`endif

    note_ram #(
        .ADDR_W  (ADDR_W),
        .WIDTH   (RAM_W),
        .DEPTH_P (RAM_DEPTH)
    ) u_ram (
        .clk_i   (CLK),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    // Result of the access in flight: length growth on writes, gated read data on reads.
    always_comb begin
        addr_ext_c = {1'b0, addr_q};
        hit_c      = addr_ext_c < len_q;
        len_d      = len_q;
        dout_d     = dout_q;
`ifdef NOTE_STORE_PARITY_EN
        perr_d     = 1'b0;
`endif
        if (rw_q) begin
            if (!hit_c) begin
                len_d = addr_ext_c + LEN_W'(1);
            end
        end else begin
            dout_d = hit_c ? ram_rdata[DATA_W-1:0] : '0;
`ifdef NOTE_STORE_PARITY_EN
            perr_d = hit_c && (^ram_rdata);
`endif
        end
        full_d = (len_d == LEN_MAX);
    end

    // Access sequencer with registered outputs; reset aborts any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            rw_q    <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            len_q   <= '0;
            full_q  <= 1'b0;
`ifdef NOTE_STORE_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CE) begin
                        addr_q  <= Addr;
                        din_q   <= Din;
                        rw_q    <= RW;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    state_q <= ST_DONE;
                    rdy_q   <= 1'b1;
                    dout_q  <= dout_d;
                    len_q   <= len_d;
                    full_q  <= full_d;
`ifdef NOTE_STORE_PARITY_EN
                    perr_q  <= perr_d;
`endif
                end
                ST_DONE: begin
                    // CE held high keeps us here so one assertion yields one access.
                    if (!CE) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b0;
`ifdef NOTE_STORE_PARITY_EN
                        perr_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Dout = dout_q;
    assign Rdy  = rdy_q;
    assign Len  = len_q;
    assign Full = full_q;
`ifdef NOTE_STORE_PARITY_EN
    assign PErr = perr_q;
`endif

endmodule : note_store

// File: doc/note_store.md
NOTE_STORE -- requirements
Module: note_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: address width, matching the pad's 12-bit address bus.
REQ-002 SHALL have parameter DATA_W, default 4: note code width.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port CE  input  1  chip enable from the pad controller; a high level requests one access.
REQ-006 SHALL have port RW  input  1  access type: 1 = write, 0 = read.
REQ-007 SHALL have port Addr  input  ADDR_W  access address.
REQ-008 SHALL have port Din  input  DATA_W  write data (note code).
REQ-009 SHALL have port Dout  output  DATA_W  read data, registered.
REQ-010 SHALL have port Rdy  output  1  access complete; high while the FSM is in DONE.
REQ-011 SHALL have port Len  output  ADDR_W+1  recorded length, equal to the highest written address plus 1.
REQ-012 SHALL have port Full  output  1  high when Len equals 2^ADDR_W.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL, in IDLE with CE=1 at a clock edge, latch Addr, Din and RW and move to BUSY.
REQ-015 SHALL, in BUSY, perform the single RAM access and move to DONE at the next edge, unconditionally.
REQ-016 SHALL, in DONE, assert Rdy and hold Dout stable; it SHALL stay in DONE while CE=1 and return to IDLE at the first edge with CE=0.
REQ-017 SHALL assert Rdy exactly 2 edges after the edge that sampled CE=1 in IDLE, giving a fixed 2-cycle latency.
REQ-018 SHALL perform exactly one access per CE assertion; holding CE high SHALL NOT start a second access.
REQ-019 SHALL complete an access whose CE drops during BUSY: DONE is entered, Rdy is high for one cycle, then the FSM returns to IDLE.
REQ-020 SHALL, on a write, set Len to latched Addr+1 when latched Addr >= Len, and otherwise leave Len unchanged.
REQ-021 SHALL NOT change Len when a write hits an already-recorded address.
REQ-022 SHALL, on a read with latched Addr >= Len, return Dout = 0 without using RAM contents.
REQ-023 SHALL, on a read with latched Addr < Len, return the stored word.
REQ-024 SHALL leave Dout unchanged from its previous value on a write.
REQ-025 SHALL set Full by the rule Full = (Len == 2^ADDR_W); once Full is set, writes to addresses already recorded SHALL still succeed.
REQ-026 SHALL ignore Addr, Din and RW while in BUSY or DONE.

Reset
REQ-027 SHALL, while RST is high, force state = IDLE, Dout = 0, Rdy = 0, Len = 0 and Full = 0, asynchronously.
REQ-028 SHALL NOT clear RAM contents on reset; they are unreachable through reads until rewritten, because Len = 0.
REQ-029 SHALL abort an access on reset mid-operation: a write pending in BUSY is not committed and Rdy is not asserted.

Configuration
REQ-030 SHALL, with NOTE_STORE_PARITY_EN defined, store an even-parity bit per word and add port PErr (output, 1 bit).
REQ-031 SHALL, with NOTE_STORE_PARITY_EN defined, drive PErr = 1 in DONE after a read of a recorded address whose parity mismatches; PErr is 0 otherwise and 0 on reset.
REQ-032 SHALL, without NOTE_STORE_PARITY_EN, use a DATA_W-bit RAM and omit the PErr port.

Structure
REQ-033 SHALL take ADDR_W and DATA_W defaults, the DEPTH constant and the FSM state encoding (IDLE, BUSY, DONE) from shared package note_store_pkg.
REQ-034 SHALL instantiate sub-module note_ram: a single-port synchronous RAM of DEPTH x (DATA_W [+1]) with one-cycle read and no reset.

Verification
REQ-035 SHALL verify: RST 1 for 300 ns then 0 -> Dout=0, Rdy=0, Len=0, Full=0.
REQ-036 SHALL verify: write 0x3 at Addr 0x000, then write 0x5 at Addr 0x001, then read 0x001 -> Rdy 2 edges after each CE, Len=2, read Dout=0x5.
REQ-037 SHALL verify: CE held high for 10 cycles on a write -> one Rdy episode, exactly one write, Len increments once.
REQ-038 SHALL verify: read Addr 0x7FF with Len=2 -> Dout=0; then write 0x9 at 0x7FF -> Len=0x800; then write 0x1 at 0x010 -> Len stays 0x800.
REQ-039 SHALL verify: write Addr 0xFFF -> Len=0x1000, Full=1; then RST asserted during a BUSY write to 0x000 -> no Rdy, Len=0, and a later read of 0x000 returns 0.
REQ-040 SHALL verify (NOTE_STORE_PARITY_EN defined): corrupt the stored parity bit at Addr 0x001 by force, then read 0x001 -> PErr=1 in DONE and Dout = stored data.
